dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between the core's load/store path (CPU) and an external

---
 rtl/dmem_port_arbiter_pkg.sv | 16 +
 rtl/dmem_port_arbiter_starve_ctr.sv | 31 +++
 rtl/dmem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and
// access-owner tags.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Starvation guard: counts CPU grants that overtake a waiting DMA request
// and forces the next arbitration to DMA once the limit is reached.
module arb_starve_ctr #(
  parameter int STARVE_LIM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_grant,
  input  logic dma_grant,
  input  logic dma_req,
  output logic force_dma
);

  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (dma_grant || !dma_req) begin
      cnt <= '0;
    end else if (cpu_grant && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_dma = (cnt == LIM);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store path and a DMA
// loader port: IDLE (arbitrate) -> ACC (memory access) -> ACK (completion pulse).
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  state_e            state;
  owner_e            owner;
  logic              acc_en;
  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     next_beat;
  logic              lat_we;
  logic              lat_last;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              force_dma;
  logic              burst_open;
  logic              grant_dma;
  logic              grant_cpu;

  // An open burst (beats issued, no last, limit not hit) keeps DMA ahead of the CPU.
  always_comb begin
    burst_open = (beat_cnt != '0);
    next_beat  = beat_cnt + 1'b1;
    grant_dma  = (state == ST_IDLE) && dma_req && (burst_open || force_dma || !cpu_req);
    grant_cpu  = (state == ST_IDLE) && cpu_req && !grant_dma;
  end

  arb_starve_ctr #(
    .STARVE_LIM(STARVE_LIM)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .cpu_grant(grant_cpu),
    .dma_grant(grant_dma),
    .dma_req  (dma_req),
    .force_dma(force_dma)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_CPU;
      acc_en    <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (burst_open && !dma_req) beat_cnt <= '0;
          if (grant_dma || grant_cpu) begin
            state  <= ST_ACC;
            acc_en <= 1'b1;
            owner  <= grant_dma ? OWN_DMA : OWN_CPU;
          end
        end
        ST_ACC: begin
          state     <= ST_ACK;
          acc_en    <= 1'b0;
          cpu_ack_q <= (owner == OWN_CPU);
          dma_ack_q <= (owner == OWN_DMA);
        end
        ST_ACK: begin
          state     <= ST_IDLE;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          if (owner == OWN_DMA)
            beat_cnt <= (lat_last || (next_beat == MAX_B)) ? '0 : next_beat;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request fields and read data are pure datapath: gated at the outputs, never reset.
  always_ff @(posedge clk) begin
    if (grant_cpu) begin
      lat_we    <= cpu_we;
      lat_addr  <= cpu_addr;
      lat_wdata <= cpu_wdata;
      lat_last  <= 1'b0;
    end else if (grant_dma) begin
      lat_we    <= dma_we;
      lat_addr  <= dma_addr;
      lat_wdata <= dma_wdata;
      lat_last  <= dma_last;
    end
    if (state == ST_ACC) rdata_q <= mem_rdata;
  end

  // A reset arriving at the end of ACC suppresses the strobe so the access aborts.
  assign mem_en    = acc_en & rst;
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = mem_en ? lat_addr : '0;
  assign mem_wdata = mem_we ? lat_wdata : '0;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_ack_q ? rdata_q : '0;
  assign dma_rdata = dma_ack_q ? rdata_q : '0;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized CPU/DMA
// traffic, all checked every cycle against a timeline model of the arbiter.
module tb_dmem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int MAX_BURST  = 4;
  localparam int STARVE_LIM = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [7:0] dma_addr = '0, dma_wdata = '0;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ack, cpu_stall, dma_ack, mem_en, mem_we;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;   // 0 directed, 1 random traffic, 2 drain
  int obs[$];        // ack order as seen on the DUT: 0 = CPU, 1 = DMA

  // timeline model: ph 0 = free, 1 = memory cycle, 2 = ack cycle
  int         ph = 0, starve = 0, beats = 0;
  bit         own_dma = 1'b0, m_we = 1'b0, m_last = 1'b0;
  logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model by one clock.
  always @(negedge clk) begin
    bit e_en, c_ack, d_ack, gd, gc;
    e_en  = (ph == 1) && rst;
    c_ack = (ph == 2) && !own_dma;
    d_ack = (ph == 2) && own_dma;
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_en && m_we);
    if (e_en) begin
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("cpu_ack", cpu_ack, c_ack);
    chk("dma_ack", dma_ack, d_ack);
    chk("cpu_rdata", cpu_rdata, c_ack ? m_rdata : 8'h00);
    chk("dma_rdata", dma_rdata, d_ack ? m_rdata : 8'h00);
    chk("cpu_stall", cpu_stall, cpu_req && !cpu_ack);
    if (cpu_ack) obs.push_back(0);
    if (dma_ack) obs.push_back(1);

    if (!dma_req) starve = 0;
    if (!rst) begin
      ph = 0; starve = 0; beats = 0;
    end else if (ph == 0) begin
      if (beats > 0 && !dma_req) beats = 0;
      gd = dma_req && (beats > 0 || starve == STARVE_LIM || !cpu_req);
      gc = cpu_req && !gd;
      if (gd) begin
        starve = 0; own_dma = 1'b1; ph = 1;
        m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata; m_last = dma_last;
      end else if (gc) begin
        if (dma_req && starve < STARVE_LIM) starve++;
        own_dma = 1'b0; ph = 1;
        m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; m_last = 1'b0;
      end
    end else if (ph == 1) begin
      m_rdata = ref_mem[m_addr];
      if (m_we) ref_mem[m_addr] = m_wdata;
      ph = 2;
    end else begin
      if (own_dma) begin
        beats++;
        if (m_last || beats == MAX_BURST) beats = 0;
      end
      ph = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the ack, leaving req high if keep.
  task automatic cpu_txn(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                         input bit keep, output logic [7:0] rd, output int lat, output int stall);
    bit got = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = -1; stall = 0; rd = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (cpu_stall) stall++;
      if (cpu_ack) begin got = 1'b1; lat = c; rd = cpu_rdata; break; end
    end
    if (!got) chk("cpu_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep) cpu_req = 1'b0;
  endtask

  task automatic dma_txn(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                         input bit last, input bit keep, output logic [7:0] rd, output int lat);
    bit got = 1'b0;
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd; dma_last = last;
    lat = -1; rd = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dma_ack) begin got = 1'b1; lat = c; rd = dma_rdata; break; end
    end
    if (!got) chk("dma_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep) dma_req = 1'b0;
  endtask

  initial begin : cpu_agent
    bit done;
    forever begin
      @(negedge clk); done = cpu_ack;
      @(posedge clk); #1;
      if (mode != 0) begin
        if (done) cpu_req = 1'b0;
        if (mode == 1 && !cpu_req && $urandom_range(0, 99) < 45) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
        end
      end
    end
  end

  initial begin : dma_agent
    bit done;
    forever begin
      @(negedge clk); done = dma_ack;
      @(posedge clk); #1;
      if (mode != 0) begin
        if (done) dma_req = 1'b0;
        if (mode == 1 && !dma_req && $urandom_range(0, 99) < 50) begin
          dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
          dma_addr = 8'($urandom_range(0, 15)); dma_wdata = 8'($urandom);
          dma_last = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  initial begin : main
    logic [7:0] rd, rd2;
    int lat, lat2, stall, k;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom); ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_dma_ack", dma_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // CPU load, no DMA traffic
    cpu_txn(1'b0, 8'h10, 8'h00, 1'b0, rd, lat, stall);
    chk("t1_lat", lat, 2);
    chk("t1_rdata", rd, 8'h5A);

    // CPU store then readback
    cpu_txn(1'b1, 8'h03, 8'h22, 1'b0, rd, lat, stall);
    chk("t2_lat", lat, 2);
    chk("t2_stall_cycles", stall, 2);
    chk("t2_mem", mem[8'h03], 8'h22);
    cpu_txn(1'b0, 8'h03, 8'h00, 1'b0, rd, lat, stall);
    chk("t2_readback", rd, 8'h22);

    // simultaneous requests with no starvation history
    fork
      begin cpu_txn(1'b0, 8'h05, 8'h00, 1'b0, rd, lat, stall); end
      begin dma_txn(1'b0, 8'h06, 8'h00, 1'b1, 1'b0, rd2, lat2); end
    join
    chk("t3_cpu_lat", lat, 2);
    chk("t3_dma_lat", lat2, 5);
    chk("t3_dma_rdata", rd2, ref_mem[8'h06]);

    // CPU held continuously against a waiting DMA request
    obs.delete();
    fork
      begin dma_txn(1'b0, 8'h20, 8'h00, 1'b1, 1'b0, rd2, lat2); end
      begin
        for (int i = 0; i < 9; i++) cpu_txn(1'b0, 8'(i), 8'h00, (i < 8), rd, lat, stall);
      end
    join
    k = -1;
    foreach (obs[i]) if (obs[i] == 1 && k < 0) k = i;
    chk("t4_cpu_before_dma", k, 8);
    chk("t4_dma_lat", lat2, 26);
    chk("t4_cpu9_lat", lat, 5);

    // 6-beat DMA burst with a CPU request arriving one cycle later
    obs.delete();
    fork
      begin
        for (int i = 0; i < 6; i++)
          dma_txn(1'b1, 8'(8'h40 + i), 8'(8'hA0 + i), 1'b0, (i < 5), rd2, lat2);
      end
      begin @(posedge clk); #1; cpu_txn(1'b0, 8'h10, 8'h00, 1'b0, rd, lat, stall); end
    join
    chk("t5_len", obs.size(), 7);
    for (int i = 0; i < 7 && i < obs.size(); i++) chk("t5_order", obs[i], (i == 4) ? 0 : 1);
    for (int i = 0; i < 6; i++) chk("t5_mem", mem[8'h40 + i], 8'(8'hA0 + i));

    // reset asserted while a CPU load is in its memory cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    chk("t6_mem_en", mem_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_ack", cpu_ack, 1'b0);
      chk("t6_rdata", cpu_rdata, 8'h00);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_txn(1'b0, 8'h10, 8'h00, 1'b0, rd, lat, stall);
    chk("t6_after_lat", lat, 2);
    chk("t6_after_rdata", rd, 8'h5A);

    // random mixed traffic, then drain outstanding requests
    mode = 1;
    repeat (3000) @(posedge clk);
    #1 mode = 2;
    k = 0;
    while ((cpu_req || dma_req) && k < 300) begin @(posedge clk); k++; end
    chk("drain_done", (cpu_req || dma_req), 1'b0);
    #1 mode = 0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
